hysteresis_edge_tracker: RTL and testbench

- Final Canny stage; sits directly downstream of double thresholding.
- Consumes the per-pixel raster stream of 2-bit strength codes and emits a binary edge map.
- Output rule: a pixel is an edge if it is strong, or if it is weak and any 8-neighbour is strong (single-pass, 3x3 hysteresis).
- Holds two strength line buffers and a 3x3 window; flushes the last row internally at end of frame.

---
 rtl/definitions_pkg.sv | 34 +++
 rtl/strength_line_buffer.sv | 37 +++
 rtl/hysteresis_edge_tracker.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_hysteresis_edge_tracker.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/definitions_pkg.sv
// Shared types and constants for the hysteresis edge tracker.
// Optional statistics are enabled by defining HYST_EDGE_STATS_EN.
package definitions_pkg;

    // Strength codes produced by double thresholding (2'b11 behaves as discard)
    typedef enum logic [1:0] {
        STR_DISCARD = 2'b00,
        STR_STRONG  = 2'b01,
        STR_WEAK    = 2'b10
    } strength_t;

    // Frame sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } hyst_state_t;

    // Per-pixel edge decision values before mapping to the output byte
    localparam logic EDGE_ON  = 1'b1;
    localparam logic EDGE_OFF = 1'b0;

    // True when a code marks a strong pixel
    function automatic logic is_strong(input logic [1:0] code);
        return code == STR_STRONG;
    endfunction

    // True when a code marks a weak pixel
    function automatic logic is_weak(input logic [1:0] code);
        return code == STR_WEAK;
    endfunction

endpackage

// File: rtl/strength_line_buffer.sv
// One-row delay line for 2-bit strength codes. The read is combinational
// from the current pointer and the same slot is overwritten on enable, so
// dout is always the code written DEPTH enables earlier.
module strength_line_buffer #(
    parameter int DEPTH = 640
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] din,
    output logic [1:0] dout
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [1:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q;

    assign dout = mem_q[ptr_q];

    // Storage is left uninitialised; the tracker masks rows that hold stale data
    always_ff @(posedge clk) begin
        if (en) begin
            mem_q[ptr_q] <= din;
        end
    end

    // Circular pointer advancing once per shifted pixel
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (en) begin
            ptr_q <= (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/hysteresis_edge_tracker.sv
// Single-pass 3x3 hysteresis: a pixel is an edge when strong, or weak with a
// strong 8-neighbour. Output for raster index k-IMG_WIDTH-1 is registered the
// cycle after input index k is accepted; the last row is drained by a flush
// of IMG_WIDTH+1 synthetic discard pixels.
// Optional per-frame statistics are enabled by defining HYST_EDGE_STATS_EN.
module hysteresis_edge_tracker
    import definitions_pkg::*;
#(
    parameter int          IMG_WIDTH  = 640,
    parameter int          IMG_HEIGHT = 480,
    parameter logic [7:0]  EDGE_VAL   = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  strength,
    input  logic        strength_valid,
    input  logic        frame_start,
    output logic [7:0]  edge_pixel,
    output logic        edge_valid,
    output logic        edge_sof,
    output logic        edge_eol,
    output logic        busy
`ifdef HYST_EDGE_STATS_EN
    ,
    output logic [31:0] stat_strong,
    output logic [31:0] stat_weak,
    output logic [31:0] stat_edges,
    output logic        stat_valid
`endif
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam int FL_W  = $clog2(IMG_WIDTH + 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    // Window column: [0]=row above centre, [1]=centre row, [2]=row below
    typedef logic [2:0][1:0] win_col_t;

    hyst_state_t      state_q, state_d;
    logic [COL_W-1:0] in_col_q, in_col_d;
    logic [ROW_W-1:0] in_row_q, in_row_d;
    logic [COL_W-1:0] out_col_q, out_col_d;
    logic [ROW_W-1:0] out_row_q, out_row_d;
    logic [FL_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic       take;
    logic       produce;
    logic       shift_en;
    logic       fill_done;
    logic       last_in;
    logic       flush_last;
    logic [1:0] pix_in;

    win_col_t   win_q [3];
    win_col_t   win_d [3];
    logic [1:0] lb_in  [2];
    logic [1:0] lb_out [2];
    logic [2:0] col_ok;
    logic [2:0] row_ok;
    logic [8:0] tap_strong;
    logic       nb_strong;
    logic       is_edge;

    logic [7:0] edge_pixel_q;
    logic       edge_valid_q, edge_sof_q, edge_eol_q;

    // A pixel enters the pipeline in FILL/RUN, or in IDLE only when it starts a frame;
    // anything offered during FLUSH is dropped
    assign take = strength_valid &&
                  ((state_q == FILL) || (state_q == RUN) ||
                   ((state_q == IDLE) && frame_start));

    assign fill_done  = (in_row_q == ROW_W'(1)) && (in_col_q == COL_W'(1));
    assign last_in    = (in_row_q == ROW_LAST) && (in_col_q == COL_LAST);
    assign flush_last = (state_q == FLUSH) && (flush_cnt_q == FL_W'(IMG_WIDTH));

    assign produce = (state_q == FLUSH) ||
                     (take && !frame_start &&
                      ((state_q == RUN) || ((state_q == FILL) && fill_done)));

    assign shift_en = take || (state_q == FLUSH);
    assign pix_in   = (state_q == FLUSH) ? 2'b00 : strength;
    assign busy     = (state_q == FLUSH);

    // Two chained row delays: lb_out[0] is row r-1, lb_out[1] is row r-2
    assign lb_in[0] = pix_in;
    assign lb_in[1] = lb_out[0];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lb
            strength_line_buffer #(
                .DEPTH (IMG_WIDTH)
            ) u_lb (
                .clk   (clk),
                .reset (reset),
                .en    (shift_en),
                .din   (lb_in[gi]),
                .dout  (lb_out[gi])
            );
        end
    endgenerate

    // Next window: shift left, newest column from the line buffers and input
    always_comb begin
        win_d[0] = win_q[1];
        win_d[1] = win_q[2];
        win_d[2] = {pix_in, lb_out[0], lb_out[1]};
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_win
            // Window column register, advanced with every shifted pixel
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    win_q[gi] <= '0;
                end else if (shift_en) begin
                    win_q[gi] <= win_d[gi];
                end
            end
        end
    endgenerate

    // Taps are masked from the centre's coordinates, so the wrapped column
    // at a row boundary and out-of-frame rows never contribute
    assign col_ok = {out_col_q != COL_LAST, 1'b1, out_col_q != '0};
    assign row_ok = {out_row_q != ROW_LAST, 1'b1, out_row_q != '0};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_tap_col
            for (genvar gj = 0; gj < 3; gj++) begin : g_tap_row
                assign tap_strong[gi*3+gj] = is_strong(win_d[gi][gj]) &&
                                             col_ok[gi] && row_ok[gj];
            end
        end
    endgenerate

    assign nb_strong = |(tap_strong & 9'b111_101_111);

    // Edge decision for the centre pixel of the updated window
    always_comb begin
        is_edge = EDGE_OFF;
        if (is_strong(win_d[1][1]) || (is_weak(win_d[1][1]) && nb_strong)) begin
            is_edge = EDGE_ON;
        end
    end

    // Sequencing and raster counters for the input and the output centre
    always_comb begin
        state_d     = state_q;
        in_col_d    = in_col_q;
        in_row_d    = in_row_q;
        out_col_d   = out_col_q;
        out_row_d   = out_row_q;
        flush_cnt_d = flush_cnt_q;

        if (produce) begin
            if (out_col_q == COL_LAST) begin
                out_col_d = '0;
                out_row_d = (out_row_q == ROW_LAST) ? '0 : out_row_q + 1'b1;
            end else begin
                out_col_d = out_col_q + 1'b1;
            end
        end

        case (state_q)
            IDLE, FILL, RUN: begin
                if (take) begin
                    if (frame_start) begin
                        // New frame (or abort of the current one): this pixel is (0,0)
                        state_d   = FILL;
                        in_col_d  = COL_W'(1);
                        in_row_d  = '0;
                        out_col_d = '0;
                        out_row_d = '0;
                    end else begin
                        if (in_col_q == COL_LAST) begin
                            in_col_d = '0;
                            in_row_d = (in_row_q == ROW_LAST) ? '0 : in_row_q + 1'b1;
                        end else begin
                            in_col_d = in_col_q + 1'b1;
                        end
                        if ((state_q == FILL) && fill_done) begin
                            state_d = RUN;
                        end
                        if ((state_q == RUN) && last_in) begin
                            state_d     = FLUSH;
                            flush_cnt_d = '0;
                        end
                    end
                end
            end
            FLUSH: begin
                flush_cnt_d = flush_cnt_q + 1'b1;
                if (flush_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            in_col_q    <= '0;
            in_row_q    <= '0;
            out_col_q   <= '0;
            out_row_q   <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            in_col_q    <= in_col_d;
            in_row_q    <= in_row_d;
            out_col_q   <= out_col_d;
            out_row_q   <= out_row_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Registered output stream with frame/row markers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_pixel_q <= '0;
            edge_valid_q <= 1'b0;
            edge_sof_q   <= 1'b0;
            edge_eol_q   <= 1'b0;
        end else begin
            edge_valid_q <= produce;
            edge_pixel_q <= (produce && is_edge) ? EDGE_VAL : 8'h00;
            edge_sof_q   <= produce && (out_col_q == '0) && (out_row_q == '0);
            edge_eol_q   <= produce && (out_col_q == COL_LAST);
        end
    end

    assign edge_pixel = edge_pixel_q;
    assign edge_valid = edge_valid_q;
    assign edge_sof   = edge_sof_q;
    assign edge_eol   = edge_eol_q;

`ifdef HYST_EDGE_STATS_EN
    logic [31:0] cnt_strong_q, cnt_weak_q, cnt_edges_q;
    logic [31:0] stat_strong_q, stat_weak_q, stat_edges_q;
    logic        stat_valid_q;
    logic        restart;

    assign restart = take && frame_start;

    // Running per-frame counts, restarted by the first pixel of a frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_strong_q <= '0;
            cnt_weak_q   <= '0;
            cnt_edges_q  <= '0;
        end else begin
            if (restart) begin
                cnt_strong_q <= 32'(is_strong(strength));
                cnt_weak_q   <= 32'(is_weak(strength));
                cnt_edges_q  <= '0;
            end else begin
                if (take) begin
                    cnt_strong_q <= cnt_strong_q + 32'(is_strong(strength));
                    cnt_weak_q   <= cnt_weak_q + 32'(is_weak(strength));
                end
                if (produce) begin
                    cnt_edges_q <= cnt_edges_q + 32'(is_edge);
                end
            end
        end
    end

    // Snapshot when the flush completes, including the final drained output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_strong_q <= '0;
            stat_weak_q   <= '0;
            stat_edges_q  <= '0;
            stat_valid_q  <= 1'b0;
        end else begin
            stat_valid_q <= flush_last;
            if (flush_last) begin
                stat_strong_q <= cnt_strong_q;
                stat_weak_q   <= cnt_weak_q;
                stat_edges_q  <= cnt_edges_q + 32'(is_edge);
            end
        end
    end

    assign stat_strong = stat_strong_q;
    assign stat_weak   = stat_weak_q;
    assign stat_edges  = stat_edges_q;
    assign stat_valid  = stat_valid_q;
`endif

    // Upstream must hold off while the tracker drains the last row
    a_no_input_in_flush : assert property (@(posedge clk) disable iff (reset)
        !((state_q == FLUSH) && strength_valid));

endmodule

// File: tb/tb_hysteresis_edge_tracker.sv
// Self-checking bench for hysteresis_edge_tracker at 4x3. Table vectors,
// hand sequences (reset mid-frame, abort by frame_start) and random frames
// checked against a neighbourhood model. Define HYST_EDGE_STATS_EN to also
// check the statistics outputs.
module tb_hysteresis_edge_tracker;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] strength;
    logic       strength_valid;
    logic       frame_start;
    logic [7:0] edge_pixel;
    logic       edge_valid, edge_sof, edge_eol, busy;
`ifdef HYST_EDGE_STATS_EN
    logic [31:0] stat_strong, stat_weak, stat_edges;
    logic        stat_valid;
`endif

    always #5 clk = ~clk;

    hysteresis_edge_tracker #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .EDGE_VAL   (8'hFF)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .strength       (strength),
        .strength_valid (strength_valid),
        .frame_start    (frame_start),
        .edge_pixel     (edge_pixel),
        .edge_valid     (edge_valid),
        .edge_sof       (edge_sof),
        .edge_eol       (edge_eol),
        .busy           (busy)
`ifdef HYST_EDGE_STATS_EN
        ,
        .stat_strong    (stat_strong),
        .stat_weak      (stat_weak),
        .stat_edges     (stat_edges),
        .stat_valid     (stat_valid)
`endif
    );

    typedef struct packed {
        logic [7:0] px;
        logic       sof;
        logic       eol;
    } out_t;

    typedef struct {
        string       name;
        logic [23:0] f;
        logic [11:0] exp;
    } vec_t;

    out_t cap_q[$];
    int   busy_cycles = 0;
    int   stat_pulses = 0;
    int   errors = 0;
    int   checks = 0;

    // Capture every output and count busy / stat pulses away from the active edge
    always @(negedge clk) begin
        if (edge_valid) cap_q.push_back({edge_pixel, edge_sof, edge_eol});
        if (busy) busy_cycles++;
`ifdef HYST_EDGE_STATS_EN
        if (stat_valid) stat_pulses++;
`endif
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: strong, or weak with an in-frame strong 8-neighbour
    function automatic logic model_edge(input logic [23:0] f, input int idx);
        int r = idx / W;
        int c = idx % W;
        logic [1:0] s = f[2*idx +: 2];
        if (s == 2'b01) return 1'b1;
        if (s != 2'b10) return 1'b0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                int rr = r + dr;
                int cc = c + dc;
                if (dr == 0 && dc == 0) continue;
                if (rr < 0 || rr >= H || cc < 0 || cc >= W) continue;
                if (f[2*(rr*W+cc) +: 2] == 2'b01) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic logic [23:0] put(input logic [23:0] f, input int idx, input logic [1:0] s);
        logic [23:0] g = f;
        g[2*idx +: 2] = s;
        return g;
    endfunction

    task automatic send_pixel(input logic [1:0] s, input logic fs, input int gap_max);
        int t = 0;
        while (busy && t < 100) begin
            step();
            t++;
        end
        if (busy) begin
            errors++;
            checks++;
            $display("FAIL busy_timeout: busy still %0b expected 0", busy);
        end
        strength       = s;
        strength_valid = 1'b1;
        frame_start    = fs;
        step();
        strength_valid = 1'b0;
        frame_start    = 1'b0;
        strength       = 2'b00;
        repeat ($urandom_range(0, gap_max)) step();
    endtask

    task automatic send_frame(input logic [23:0] f, input int gap_max);
        for (int i = 0; i < N; i++) send_pixel(f[2*i +: 2], i == 0, gap_max);
    endtask

    task automatic wait_outputs(input string name, input int total);
        int t = 0;
        while (cap_q.size() < total && t < 200) begin
            step();
            t++;
        end
        repeat (W + 4) step();
        check({name, "_count"}, cap_q.size(), total);
    endtask

    // Compare count outputs starting at first against model or table bits
    task automatic compare(input string name, input logic [23:0] f, input logic [11:0] exp,
                           input bit use_model, input int first, input int count);
        for (int i = 0; i < count; i++) begin
            out_t o;
            logic e;
            if (first + i >= cap_q.size()) break;
            o = cap_q[first + i];
            e = use_model ? model_edge(f, i) : exp[i];
            $display("  %s out[%0d] px=%02h sof=%0b eol=%0b", name, i, o.px, o.sof, o.eol);
            check($sformatf("%s_px%0d", name, i), {24'h0, o.px}, e ? 32'hFF : 32'h0);
            check($sformatf("%s_sof%0d", name, i), {31'h0, o.sof}, {31'h0, i == 0});
            check($sformatf("%s_eol%0d", name, i), {31'h0, o.eol}, {31'h0, (i % W) == W - 1});
        end
    endtask

    task automatic run_and_check(input string name, input logic [23:0] f, input logic [11:0] exp,
                                 input bit use_model, input int gap_max);
        int b0  = cap_q.size();
        int bc0 = busy_cycles;
        send_frame(f, gap_max);
        wait_outputs(name, b0 + N);
        check({name, "_busy_cycles"}, busy_cycles - bc0, W + 1);
        compare(name, f, exp, use_model, b0, N);
    endtask

    vec_t vecs[6];

    initial begin
        logic [23:0] f, fa;
        int b0, bc0;

        vecs[0].name = "all_strong"; vecs[0].f = {12{2'b01}};           vecs[0].exp = 12'hFFF;
        vecs[1].name = "lone_weak";  vecs[1].f = put(24'h0, 5, 2'b10);  vecs[1].exp = 12'h000;
        vecs[2].name = "weak_diag";  vecs[2].f = put(put(24'h0, 5, 2'b10), 0, 2'b01); vecs[2].exp = 12'h021;
        vecs[3].name = "wrap_apart"; vecs[3].f = put(put(24'h0, 3, 2'b01), 4, 2'b10); vecs[3].exp = 12'h008;
        vecs[4].name = "wrap_near";  vecs[4].f = put(put(24'h0, 3, 2'b01), 6, 2'b10); vecs[4].exp = 12'h048;
        vecs[5].name = "all_weak";   vecs[5].f = {12{2'b10}};           vecs[5].exp = 12'h000;

        reset = 1'b1;
        strength = 2'b00;
        strength_valid = 1'b0;
        frame_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'h0, edge_valid}, 32'h0);
        check("rst_pixel", {24'h0, edge_pixel}, 32'h0);
        check("rst_sof",   {31'h0, edge_sof}, 32'h0);
        check("rst_eol",   {31'h0, edge_eol}, 32'h0);
        check("rst_busy",  {31'h0, busy}, 32'h0);
        reset = 1'b0;
        step();

        // A pixel without frame_start while idle must be ignored
        send_pixel(2'b01, 1'b0, 0);
        repeat (3) step();
        check("idle_no_start", cap_q.size(), 0);

        for (int v = 0; v < 6; v++) begin
            run_and_check(vecs[v].name, vecs[v].f, vecs[v].exp, 1'b0, v % 2);
        end

        // Reset in the middle of RUN, right while an output is on the port
        for (int i = 0; i < 6; i++) send_pixel(2'b01, i == 0, 0);
        check("pre_rst_valid", {31'h0, edge_valid}, 32'h1);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", {31'h0, edge_valid}, 32'h0);
        check("mid_rst_pixel", {24'h0, edge_pixel}, 32'h0);
        check("mid_rst_busy",  {31'h0, busy}, 32'h0);
        step();
        step();
        reset = 1'b0;
        step();
        run_and_check("post_rst_weak", {12{2'b10}}, 12'h000, 1'b0, 0);

        // frame_start mid-frame aborts without flush; 7 inputs yield 2 outputs
        fa = '0;
        for (int i = 0; i < N; i++) fa[2*i +: 2] = 2'($urandom_range(0, 3));
        fa = put(fa, 1, 2'b10);
        fa = put(fa, 6, 2'b01);
        b0  = cap_q.size();
        for (int i = 0; i < 7; i++) send_pixel(fa[2*i +: 2], i == 0, 1);
        bc0 = busy_cycles;
        f = {12{2'b10}};
        f = put(f, 9, 2'b01);
        send_frame(f, 1);
        wait_outputs("abort", b0 + 2 + N);
        check("abort_busy_cycles", busy_cycles - bc0, W + 1);
        compare("abort_old", fa, 12'h0, 1'b1, b0, 2);
        compare("abort_new", f, 12'h0, 1'b1, b0 + 2, N);

        // Random frames against the model
        for (int n = 0; n < 15; n++) begin
            f = '0;
            for (int i = 0; i < N; i++) f[2*i +: 2] = 2'($urandom_range(0, 3));
            run_and_check($sformatf("rand%0d", n), f, 12'h0, 1'b1, 2);
        end

`ifdef HYST_EDGE_STATS_EN
        begin
            int sp0 = stat_pulses;
            f = '0;
            f = put(f, 0, 2'b01);
            f = put(f, 3, 2'b01);
            f = put(f, 11, 2'b01);
            f = put(f, 1, 2'b10);
            f = put(f, 9, 2'b10);
            run_and_check("stats", f, 12'h80B, 1'b0, 0);
            check("stat_strong", stat_strong, 32'd3);
            check("stat_weak",   stat_weak, 32'd2);
            check("stat_edges",  stat_edges, 32'd4);
            check("stat_pulses", stat_pulses - sp0, 32'd1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
